// File: rtl/cpu1_mem_arbiter.sv
// Two-master round-robin arbiter in front of the CPU1 single-port RAM.
// Serialises Avalon-MM requests from the instruction (m0) and data (m1) masters.
module cpu1_mem_arbiter #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter bit FAVOR_M0_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  // lastGrant encodes the most recently served master: 0 = m0, 1 = m1.
  logic lastGrant_q, lastGrant_d;
  logic rdPend_q, rdPend_d;
  logic rdOwner_q, rdOwner_d;
  logic req0, req1, grant0, grant1, accRead;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b1 & 1'b0;
    if (!reset && !stall) begin
      if (req0 && (!req1 || lastGrant_q)) begin
        grant0 = 1'b1;
      end else if (req1) begin
        grant1 = 1'b1;
      end
    end
  end

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (grant0) begin
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
    end else if (grant1) begin
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end
  end

  assign mem_clken = ~stall;

  // A master raising read and write together is served as a write only.
  assign accRead = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);

  always_comb begin
    lastGrant_d = (grant0 | grant1) ? grant1 : lastGrant_q;
    rdPend_d    = accRead;
    rdOwner_d   = accRead ? grant1 : rdOwner_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant_q <= FAVOR_M0_RESET ? 1'b1 : 1'b0;
      rdPend_q    <= 1'b0;
      rdOwner_q   <= 1'b0;
    end else begin
      lastGrant_q <= lastGrant_d;
      rdPend_q    <= rdPend_d;
      rdOwner_q   <= rdOwner_d;
    end
  end

  assign m0_readdatavalid = rdPend_q & ~rdOwner_q;
  assign m1_readdatavalid = rdPend_q & rdOwner_q;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_cpu1_mem_arbiter.sv
// Directed bench for cpu1_mem_arbiter with a behavioural 1024x32 RAM and
// per-master read-data scoreboards.
module tb_cpu1_mem_arbiter;

  localparam logic [31:0] DATA_05  = 32'hDEADBEEF;
  localparam logic [31:0] DATA_10  = 32'h0BADF00D;
  localparam logic [31:0] DATA_20  = 32'h12345678;
  localparam logic [31:0] DATA_3FF = 32'hAAAAAAAA;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [9:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  logic [31:0] ram [0:1023];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] expData0, expData1;
  int vectors = 0;
  int miscompares = 0;

  cpu1_mem_arbiter dut (
    .clk(clk), .reset(reset), .stall(stall),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: registered read, byte-lane writes, everything gated by clken.
  always @(posedge clk) begin
    if (reset) begin
      ram[10'h001] <= 32'h0;
      ram[10'h005] <= DATA_05;
      ram[10'h010] <= DATA_10;
      ram[10'h020] <= DATA_20;
      ram[10'h3FF] <= DATA_3FF;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [9:0] a0,
                               input logic [31:0] d0, input logic r1, input logic w1,
                               input logic [9:0] a1, input logic [31:0] d1,
                               input logic [3:0] be1);
    m0_read = r0; m0_write = w0; m0_address = a0; m0_writedata = d0; m0_byteenable = 4'hF;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_writedata = d1; m1_byteenable = be1;
    #1;
  endtask

  // Read-data scoreboard: every returned beat must match the oldest expectation.
  always @(negedge clk) begin
    if (m0_readdatavalid) begin
      if (q0.size() == 0) checkOutput("m0_spurious_rdv", 32'(m0_readdatavalid), 32'd0);
      else begin
        expData0 = q0.pop_front();
        checkOutput("m0_readdata", m0_readdata, expData0);
      end
    end
    if (m1_readdatavalid) begin
      if (q1.size() == 0) checkOutput("m1_spurious_rdv", 32'(m1_readdatavalid), 32'd0);
      else begin
        expData1 = q1.pop_front();
        checkOutput("m1_readdata", m1_readdata, expData1);
      end
    end
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    applyStimulus(1, 0, 10'h010, 0, 1, 0, 10'h020, 0, 4'hF);
    checkOutput("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
    checkOutput("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
    checkOutput("rst_cs", 32'(mem_chipselect), 32'd0);
    checkOutput("rst_m0_rdv", 32'(m0_readdatavalid), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
    tick();

    // Contention: grants alternate starting with m0 after reset.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 10'h010, 0, 1, 0, 10'h020, 0, 4'hF);
      checkOutput("cont_m0_wait", 32'(m0_waitrequest), 32'(i % 2));
      checkOutput("cont_m1_wait", 32'(m1_waitrequest), 32'((i + 1) % 2));
      checkOutput("cont_addr", 32'(mem_address), (i % 2 == 0) ? 32'h010 : 32'h020);
      checkOutput("cont_m0_rdv", 32'(m0_readdatavalid), 32'(i > 0 && (i - 1) % 2 == 0));
      checkOutput("cont_m1_rdv", 32'(m1_readdatavalid), 32'(i > 0 && (i - 1) % 2 == 1));
      if (i % 2 == 0) q0.push_back(DATA_10);
      else q1.push_back(DATA_20);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
    checkOutput("cont_last_m1_rdv", 32'(m1_readdatavalid), 32'd1);
    tick();

    // Basic read by m0.
    applyStimulus(1, 0, 10'h005, 0, 0, 0, 0, 0, 4'hF);
    checkOutput("rd_m0_wait", 32'(m0_waitrequest), 32'd0);
    checkOutput("rd_addr", 32'(mem_address), 32'h005);
    checkOutput("rd_cs", 32'(mem_chipselect), 32'd1);
    checkOutput("rd_memwrite", 32'(mem_write), 32'd0);
    q0.push_back(DATA_05);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
    checkOutput("rd_m0_rdv", 32'(m0_readdatavalid), 32'd1);
    checkOutput("rd_m1_rdv", 32'(m1_readdatavalid), 32'd0);
    tick();

    // Byte-lane write by m1, then read-back.
    applyStimulus(0, 0, 0, 0, 0, 1, 10'h3FF, 32'h11223344, 4'b0101);
    checkOutput("bw_m1_wait", 32'(m1_waitrequest), 32'd0);
    checkOutput("bw_memwrite", 32'(mem_write), 32'd1);
    checkOutput("bw_be", 32'(mem_byteenable), 32'h5);
    checkOutput("bw_wdata", mem_writedata, 32'h11223344);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 10'h3FF, 0, 4'hF);
    checkOutput("bw_no_rdv", 32'(m1_readdatavalid), 32'd0);
    q1.push_back(32'hAA22AA44);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
    checkOutput("bw_rb_rdv", 32'(m1_readdatavalid), 32'd1);
    tick();

    // Read and write raised together on m0 is a write.
    applyStimulus(1, 1, 10'h001, 32'h0000CAFE, 0, 0, 0, 0, 4'hF);
    checkOutput("rw_memwrite", 32'(mem_write), 32'd1);
    tick();
    applyStimulus(1, 0, 10'h001, 0, 0, 0, 0, 0, 4'hF);
    checkOutput("rw_no_rdv", 32'(m0_readdatavalid), 32'd0);
    q0.push_back(32'h0000CAFE);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
    tick();

    // Stall for three cycles with a read in flight.
    applyStimulus(1, 0, 10'h005, 0, 0, 0, 0, 0, 4'hF);
    checkOutput("st_wait0", 32'(m0_waitrequest), 32'd0);
    q0.push_back(DATA_05);
    tick();
    stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checkOutput("st_rdv", 32'(m0_readdatavalid), 32'(k == 1));
      checkOutput("st_clken", 32'(mem_clken), 32'd0);
      checkOutput("st_wait", 32'(m0_waitrequest), 32'd1);
      checkOutput("st_cs", 32'(mem_chipselect), 32'd0);
      tick();
    end
    stall = 1'b0;
    #1;
    checkOutput("st_regrant_wait", 32'(m0_waitrequest), 32'd0);
    checkOutput("st_regrant_cs", 32'(mem_chipselect), 32'd1);
    q0.push_back(DATA_05);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
    checkOutput("st_final_rdv", 32'(m0_readdatavalid), 32'd1);
    tick();

    // Reset lands while an m1 read is in flight.
    applyStimulus(0, 0, 0, 0, 1, 0, 10'h020, 0, 4'hF);
    checkOutput("mr_m1_wait", 32'(m1_waitrequest), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mr_rdv_now", 32'(m1_readdatavalid), 32'd0);
    checkOutput("mr_cs_in_reset", 32'(mem_chipselect), 32'd0);
    tick();
    checkOutput("mr_rdv_after_edge", 32'(m1_readdatavalid), 32'd0);
    checkOutput("mr_wait_in_reset", 32'(m1_waitrequest), 32'd1);
    reset = 1'b0;
    applyStimulus(1, 0, 10'h010, 0, 1, 0, 10'h020, 0, 4'hF);
    checkOutput("mr_m0_first", 32'(m0_waitrequest), 32'd0);
    checkOutput("mr_m1_waits", 32'(m1_waitrequest), 32'd1);
    checkOutput("mr_addr", 32'(mem_address), 32'h010);
    q0.push_back(DATA_10);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'hF);
    checkOutput("mr_m0_rdv", 32'(m0_readdatavalid), 32'd1);
    tick();
    tick();

    checkOutput("q0_drained", 32'(q0.size()), 32'd0);
    checkOutput("q1_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu1_mem_arbiter.md
Name: cpu1_mem_arbiter

Overview:
- Two-master round-robin arbiter that sits directly upstream of the CPU1 single-port on-chip RAM (1024 x 32, byte enables, 1-cycle read latency).
- Accepts Avalon-MM requests from an instruction master (m0) and a data master (m1).
- Serialises those requests onto the RAM's single port.
- Returns read data to the owning master with a registered readdatavalid.

Parameters:
- ADDR_W, 10, word address width on masters and RAM.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- FAVOR_M0_RESET, 1, if 1 the pointer after reset favours m0, else m1.

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  global hold; when high, no new grants are made and the RAM clock enable is deasserted.
- m0_address / m1_address  in  ADDR_W  word address.
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes, used for writes.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m0_waitrequest / m1_waitrequest  out  1  high means the request is not accepted this cycle.
- m0_readdata / m1_readdata  out  DATA_W  read data; meaningful only while readdatavalid is high.
- m0_readdatavalid / m1_readdatavalid  out  1  one-cycle pulse marking returned read data.
- mem_address  out  ADDR_W  to RAM.
- mem_byteenable  out  DATA_W/8  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_writedata  out  DATA_W  to RAM.
- mem_clken  out  1  to RAM.
- mem_readdata  in  DATA_W  from RAM.

Behaviour:
- Request and acceptance:
  - reqN = mN_read | mN_write.
  - A request is accepted in a cycle where reqN=1 and mN_waitrequest=0.
  - Exactly one transfer is accepted per cycle, at most.
- Grant (combinational, each cycle, only when stall=0):
  - Only one master requesting: that master is granted.
  - Both requesting: grant the master that is not last_grant.
  - Neither requesting: no grant.
- Waitrequest:
  - mN_waitrequest = reqN & ~grantN.
  - It is low when reqN=0 (Avalon idle convention).
  - stall=1 forces both waitrequests high whenever the master is requesting.
- RAM drive (combinational from the granted master):
  - mem_chipselect = any grant.
  - mem_write = granted master's write.
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted master.
  - With no grant: chipselect=0, write=0; address, byteenable and data are don't-care (drive 0).
- mem_clken = ~stall.
- Read and write both high on one master: treated as a write; no readdatavalid is produced.
- last_grant register:
  - Updated on every accepted transfer to the granted master.
  - Held otherwise.
  - Reset value: m1 if FAVOR_M0_RESET=1, else m0.
- Read return:
  - rd_pend and rd_owner registers are set on an accepted read.
  - mN_readdatavalid = rd_pend & (rd_owner==N), registered, asserted exactly 1 cycle after acceptance.
  - mN_readdata = mem_readdata, passed through unregistered.
- Back-to-back operation:
  - A new read may be accepted in the same cycle a previous read's readdatavalid is high, giving full throughput of 1 transfer/cycle.
  - rd_pend is cleared in a cycle with no accepted read.
- Stall with a read pending: readdatavalid still fires on schedule. The RAM address register holds with clken low, so q stays stable. No new reads are issued.
- Writes produce no response; they complete at acceptance.
- Reset (asynchronous, any time):
  - rd_pend=0, rd_owner=0, last_grant set to its reset value.
  - All readdatavalid outputs are 0 immediately.
  - An in-flight read is discarded.
  - Combinational outputs follow the inputs, except that grants are allowed only after reset is released.
- While reset is high:
  - mem_chipselect=0.
  - Both waitrequests are high when the master is requesting.

Test Plan:
- Basic read: after reset, m0 reads address 0x005 with the RAM preloaded with 0x5 = 0xDEADBEEF -> m0_waitrequest=0 in cycle 0; mem_address=0x005, mem_chipselect=1; m0_readdatavalid=1 in cycle 1 with m0_readdata=0xDEADBEEF; m1 outputs stay idle.
- Contention: m0 and m1 both read continuously (m0 at 0x010, m1 at 0x020) -> grants alternate m0, m1, m0, m1 starting with m0; each master gets readdatavalid every 2nd cycle with the correct data; waitrequest is high for the non-granted master.
- Byte write then read: m1 writes 0x11223344 with byteenable=0b0101 to 0x3FF, which holds 0xAAAAAAAA -> a subsequent m1 read returns 0xAA22AA44; no readdatavalid is produced for the write.
- Read+write on the same master: m0_read=m0_write=1, data 0x0000CAFE to 0x001 -> mem_write=1; no m0_readdatavalid; a read-back of 0x001 returns 0x0000CAFE.
- Stall: m0 read accepted in cycle 0, stall=1 in cycles 1-3 -> m0_readdatavalid=1 in cycle 1; mem_clken=0 and m0_waitrequest=1 in cycles 1-3 while m0 requests; the next grant is in cycle 4.
- Reset mid-read: m1 read accepted, reset asserted before the next rising edge -> m1_readdatavalid is never asserted; after release, with both masters requesting, m0 is granted first (FAVOR_M0_RESET=1).
